// File: rtl/uart_code_receiver_if.sv
// Interface between uart_code_receiver, the uart_rx byte source and the lock
// controller that consumes the code.
//   rx_data     : byte from uart_rx, valid only while rx_finished=1
//   rx_finished : one-cycle pulse marking a received byte
//   rx_enable   : enable for uart_rx
//   code        : packed BCD code, first digit received in the MSB nibble
//   code_valid  : a new code is held on code
//   code_ack    : consumer acknowledge
//   frame_error : one-cycle pulse on a malformed frame or timeout
//   busy        : a frame is in progress
// Modport slave is the receiver side; master is the side that drives the
// byte stream and acknowledges codes.
interface uart_code_receiver_if #(
    parameter int N_DIGITS = 4
);
    logic [7:0]            rx_data;
    logic                  rx_finished;
    logic                  rx_enable;
    logic [4*N_DIGITS-1:0] code;
    logic                  code_valid;
    logic                  code_ack;
    logic                  frame_error;
    logic                  busy;

    modport slave (
        input  rx_data, rx_finished, code_ack,
        output rx_enable, code, code_valid, frame_error, busy
    );

    modport master (
        output rx_data, rx_finished, code_ack,
        input  rx_enable, code, code_valid, frame_error, busy
    );
endinterface

// File: rtl/uart_code_receiver.sv
// uart_code_receiver: assembles the uart_rx byte stream into an access-code
// frame "START_CHAR d1..dN END_CHAR", packs the ASCII digits as BCD and
// presents the code to the lock controller with a valid/ack handshake.
// Malformed frames and inter-byte timeouts raise a one-cycle frame_error.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : uart_code_receiver_if.slave (rx byte side + code handshake)
//
// Optional feature: define UART_CODE_CHECKSUM_EN to require a checksum byte
// (XOR of all digit ASCII bytes) between the last digit and END_CHAR.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for START_CHAR, uart_rx enabled
// DIGITS   | collecting N_DIGITS ASCII digits
// CHECK    | waiting for the checksum byte (checksum build only)
// END_WAIT | waiting for END_CHAR
// HOLD     | code presented, waiting for code_ack, uart_rx disabled
// ERR      | one-cycle frame_error pulse
module uart_code_receiver #(
    parameter int         N_DIGITS       = 4,
    parameter logic [7:0] START_CHAR     = 8'h23,
    parameter logic [7:0] END_CHAR       = 8'h0D,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input logic                 clock,
    input logic                 reset,
    uart_code_receiver_if.slave bus
);
    localparam int CW = 4 * N_DIGITS;
    localparam int NW = $clog2(N_DIGITS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NW-1:0] LAST_DIGIT = NW'(N_DIGITS - 1);

`ifdef UART_CODE_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, DIGITS, CHECK, END_WAIT, HOLD, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, DIGITS, END_WAIT, HOLD, ERR} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] shift_q, shift_d;
    logic [CW-1:0] code_q, code_d;
    logic [NW-1:0] count_q, count_d;
    // Down-counter: loaded on every accepted byte, expiry at terminal count 0.
    logic [TW-1:0] timer_q, timer_d;
    logic [CW+3:0] shift_ext;
    logic          byte_ev, is_digit, expired;
`ifdef UART_CODE_CHECKSUM_EN
    logic [7:0]    xsum_q, xsum_d;
`endif

    assign byte_ev   = bus.rx_finished;
    assign is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    // Low nibble of an ASCII digit is its BCD value.
    assign shift_ext = {shift_q, bus.rx_data[3:0]};
    assign expired   = (timer_q == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            code_q  <= '0;
            count_q <= '0;
            timer_q <= '0;
`ifdef UART_CODE_CHECKSUM_EN
            xsum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            count_q <= count_d;
            timer_q <= timer_d;
`ifdef UART_CODE_CHECKSUM_EN
            xsum_q  <= xsum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        code_d  = code_q;
        count_d = count_q;
        timer_d = timer_q;
`ifdef UART_CODE_CHECKSUM_EN
        xsum_d  = xsum_q;
`endif
        case (state_q)
            IDLE: begin
                if (byte_ev && bus.rx_data == START_CHAR) begin
                    state_d = DIGITS;
                    shift_d = '0;
                    count_d = '0;
                    timer_d = TIMER_LOAD;
`ifdef UART_CODE_CHECKSUM_EN
                    xsum_d  = '0;
`endif
                end
            end
            DIGITS: begin
                if (byte_ev) begin
                    timer_d = TIMER_LOAD;
                    if (is_digit) begin
                        shift_d = shift_ext[CW-1:0];
                        count_d = count_q + 1'b1;
`ifdef UART_CODE_CHECKSUM_EN
                        xsum_d  = xsum_q ^ bus.rx_data;
                        if (count_q == LAST_DIGIT) state_d = CHECK;
`else
                        if (count_q == LAST_DIGIT) state_d = END_WAIT;
`endif
                    end else if (bus.rx_data == START_CHAR) begin
                        // Resynchronise on a fresh start character.
                        shift_d = '0;
                        count_d = '0;
`ifdef UART_CODE_CHECKSUM_EN
                        xsum_d  = '0;
`endif
                    end else begin
                        state_d = ERR;
                    end
                end else if (expired) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef UART_CODE_CHECKSUM_EN
            CHECK: begin
                if (byte_ev) begin
                    timer_d = TIMER_LOAD;
                    state_d = (bus.rx_data == xsum_q) ? END_WAIT : ERR;
                end else if (expired) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            END_WAIT: begin
                if (byte_ev) begin
                    timer_d = TIMER_LOAD;
                    if (bus.rx_data == END_CHAR) begin
                        state_d = HOLD;
                        code_d  = shift_q;
                    end else begin
                        state_d = ERR;
                    end
                end else if (expired) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            HOLD: begin
                if (bus.code_ack) state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
                shift_d = '0;
                count_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_enable   = (state_q != HOLD);
    assign bus.code        = code_q;
    assign bus.code_valid  = (state_q == HOLD);
    assign bus.frame_error = (state_q == ERR);
`ifdef UART_CODE_CHECKSUM_EN
    assign bus.busy = (state_q == DIGITS) || (state_q == CHECK) || (state_q == END_WAIT);
`else
    assign bus.busy = (state_q == DIGITS) || (state_q == END_WAIT);
`endif
endmodule

// File: tb/tb_uart_code_receiver.sv
module tb_uart_code_receiver;
    localparam int N  = 4;
    localparam int TO = 100;
`ifdef UART_CODE_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_code_receiver_if #(.N_DIGITS(N)) bus();

    uart_code_receiver #(
        .N_DIGITS(N), .START_CHAR(8'h23), .END_CHAR(8'h0D), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int err_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: phase 0 idle, 1 digits, 2 end wait, 3 checksum,
    // 4 holding code, 5 error pulse. Digits kept as integers in a queue.
    int         ph = 0;
    int         dq[$];
    logic [7:0] xs = 8'h00;
    int         idle = 0;
    logic [31:0] m_code = 0;

    function automatic logic [31:0] pack_digits();
        logic [31:0] v = 0;
        foreach (dq[i]) v = v * 16 + dq[i];
        return v;
    endfunction

    task automatic model_step();
        logic [7:0] b;
        b = bus.rx_data;
        if (!reset) begin
            ph = 0; m_code = 0; idle = 0; xs = 0; dq.delete();
        end else begin
            case (ph)
                5: ph = 0;
                4: if (bus.code_ack) ph = 0;
                0: if (bus.rx_finished && b == 8'h23) begin
                       ph = 1; dq.delete(); xs = 0; idle = 0;
                   end
                default: begin
                    if (bus.rx_finished) begin
                        idle = 0;
                        if (ph == 1) begin
                            if (b >= 8'h30 && b <= 8'h39) begin
                                dq.push_back(int'(b) - 48);
                                xs = xs ^ b;
                                if (dq.size() == N) ph = CK ? 3 : 2;
                            end else if (b == 8'h23) begin
                                dq.delete(); xs = 0;
                            end else begin
                                ph = 5; dq.delete();
                            end
                        end else if (ph == 3) begin
                            if (b == xs) ph = 2;
                            else begin ph = 5; dq.delete(); end
                        end else begin
                            if (b == 8'h0D) begin m_code = pack_digits(); ph = 4; end
                            else begin ph = 5; dq.delete(); end
                        end
                    end else if (idle == TO - 1) begin
                        ph = 5; dq.delete();
                    end else begin
                        idle++;
                    end
                end
            endcase
        end
    endtask

    always @(posedge clock) begin
        model_step();
        #1;
        check("code", bus.code, m_code);
        check("code_valid", bus.code_valid, ph == 4);
        check("frame_error", bus.frame_error, ph == 5);
        check("busy", bus.busy, ph >= 1 && ph <= 3);
        check("rx_enable", bus.rx_enable, ph != 4);
        if (bus.frame_error) err_pulses++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.rx_data = b;
        bus.rx_finished = 1'b1;
        @(negedge clock);
        bus.rx_finished = 1'b0;
        bus.rx_data = 8'h23;  // garbage that must be ignored while not finished
    endtask

    task automatic send_ck(input logic [7:0] b);
        if (CK) send_byte(b);
    endtask

    task automatic do_ack();
        @(negedge clock);
        bus.code_ack = 1'b1;
        @(negedge clock);
        bus.code_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int k;
        bus.rx_data = 8'h00;
        bus.rx_finished = 1'b0;
        bus.code_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("rst code", bus.code, 32'h0);
        check("rst code_valid", bus.code_valid, 0);
        check("rst rx_enable", bus.rx_enable, 1);
        check("rst busy", bus.busy, 0);
        check("rst frame_error", bus.frame_error, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // valid frame
        send_byte(8'h23); send_byte(8'h31); send_byte(8'h32);
        send_byte(8'h33); send_byte(8'h34); send_ck(8'h04);
        check("busy in frame", bus.busy, 1);
        send_byte(8'h0D);
        check("t1 code", bus.code, 32'h1234);
        check("t1 valid", bus.code_valid, 1);
        check("t1 rx_enable", bus.rx_enable, 0);
        send_byte(8'h23);  // ignored while holding
        check("t1 hold ignores rx", bus.code_valid, 1);
        do_ack();
        check("t1 ack valid", bus.code_valid, 0);
        check("t1 ack rx_enable", bus.rx_enable, 1);
        check("t1 code kept", bus.code, 32'h1234);
        do_ack();  // ack outside HOLD

        // bad digit then valid frame
        e0 = err_pulses;
        send_byte(8'h23); send_byte(8'h31); send_byte(8'h41);
        check("t2 frame_error", bus.frame_error, 1);
        check("t2 valid", bus.code_valid, 0);
        @(negedge clock);
        check("t2 error one cycle", bus.frame_error, 0);
        check("t2 pulses", err_pulses - e0, 1);
        send_byte(8'h23); send_byte(8'h39); send_byte(8'h38);
        send_byte(8'h37); send_byte(8'h36); send_ck(8'h00); send_byte(8'h0D);
        check("t2 code", bus.code, 32'h9876);
        do_ack();

        // resync
        e0 = err_pulses;
        send_byte(8'h23); send_byte(8'h31); send_byte(8'h32); send_byte(8'h23);
        send_byte(8'h35); send_byte(8'h36); send_byte(8'h37); send_byte(8'h38);
        send_ck(8'h0C); send_byte(8'h0D);
        check("t3 code", bus.code, 32'h5678);
        check("t3 no error", err_pulses - e0, 0);
        do_ack();

        // timeout
        send_byte(8'h23); send_byte(8'h31);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock); #1;
            if (bus.frame_error) begin k = i; break; end
        end
        check("t4 timeout cycles", k, 100);
        repeat (3) @(negedge clock);

        // byte on the expiry cycle wins
        e0 = err_pulses;
        send_byte(8'h23); send_byte(8'h31);
        repeat (99) @(posedge clock);
        send_byte(8'h32);
        send_byte(8'h33); send_byte(8'h34); send_ck(8'h04); send_byte(8'h0D);
        check("t4 expiry byte code", bus.code, 32'h1234);
        check("t4 expiry no error", err_pulses - e0, 0);
        // leave code_valid pending so reset must clear it
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t5 rst clears valid", bus.code_valid, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // reset mid-frame
        e0 = err_pulses;
        send_byte(8'h23); send_byte(8'h31); send_byte(8'h32);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t5 code", bus.code, 32'h0);
        check("t5 busy", bus.busy, 0);
        check("t5 rx_enable", bus.rx_enable, 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        send_byte(8'h0D);
        @(negedge clock);
        check("t5 0D ignored valid", bus.code_valid, 0);
        check("t5 0D ignored busy", bus.busy, 0);
        check("t5 no error", err_pulses - e0, 0);

`ifdef UART_CODE_CHECKSUM_EN
        e0 = err_pulses;
        send_byte(8'h23); send_byte(8'h31); send_byte(8'h32);
        send_byte(8'h33); send_byte(8'h34); send_byte(8'h05);
        check("t6 bad checksum", bus.frame_error, 1);
        send_byte(8'h0D);
        check("t6 pulses", err_pulses - e0, 1);
        check("t6 no valid", bus.code_valid, 0);
`endif

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
